// File: rtl/ppfifo_2_axi_stream_pkt.sv
// Drains one ping-pong FIFO block per AXI-Stream packet at one beat per clock,
// with a partial-keep final beat, start-of-packet user flag and status counters.
module ppfifo_2_axi_stream_pkt #(
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned KEEP_WIDTH  = DATA_WIDTH / 8,
   parameter int unsigned SIZE_WIDTH  = 24,
   parameter int unsigned COUNT_WIDTH = 32
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   i_ppfifo_rdy,
   output logic                   o_ppfifo_act,
   input  logic [SIZE_WIDTH-1:0]  i_ppfifo_size,
   input  logic [DATA_WIDTH-1:0]  i_ppfifo_data,
   output logic                   o_ppfifo_stb,
   input  logic [KEEP_WIDTH-1:0]  i_last_keep,
   output logic                   o_axi_clk,
   input  logic                   i_axi_ready,
   output logic                   o_axi_valid,
   output logic [DATA_WIDTH-1:0]  o_axi_data,
   output logic [KEEP_WIDTH-1:0]  o_axi_keep,
   output logic                   o_axi_last,
   output logic                   o_axi_user,
   output logic                   o_busy,
   output logic [COUNT_WIDTH-1:0] o_block_count,
   output logic [COUNT_WIDTH-1:0] o_beat_count
);

   typedef enum logic [1:0] {IDLE, ACTIVE, RELEASE} state_t;

   state_t                state, state_next;
   logic [SIZE_WIDTH-1:0] r_size;
   logic [SIZE_WIDTH-1:0] r_count;
   logic [KEEP_WIDTH-1:0] r_keep;
   logic                  r_first;
   logic                  activate;
   logic                  load;
   logic                  load_last;
   logic                  accept;

   assign o_axi_clk = clk;
   assign accept    = o_axi_valid && i_axi_ready;
   assign o_busy    = (state != IDLE) || o_axi_valid;

   always_comb begin
      state_next = state;
      activate   = 1'b0;
      load       = 1'b0;
      load_last  = 1'b0;
      case (state)
         IDLE: begin
            if (i_ppfifo_rdy && !o_ppfifo_act) begin
               activate   = 1'b1;
               state_next = (i_ppfifo_size == '0) ? RELEASE : ACTIVE;
            end
         end
         ACTIVE: begin
            // r_size is nonzero here, so r_size-1 cannot underflow
            load = (r_count < r_size) && (!o_axi_valid || i_axi_ready);
            if (load && (r_count == r_size - SIZE_WIDTH'(1))) begin
               load_last  = 1'b1;
               state_next = RELEASE;
            end
         end
         RELEASE: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_ppfifo_act  <= 1'b0;
         o_ppfifo_stb  <= 1'b0;
         o_axi_valid   <= 1'b0;
         o_axi_data    <= '0;
         o_axi_keep    <= '0;
         o_axi_last    <= 1'b0;
         o_axi_user    <= 1'b0;
         o_block_count <= '0;
         o_beat_count  <= '0;
         r_size        <= '0;
         r_count       <= '0;
         r_keep        <= '0;
         r_first       <= 1'b0;
      end else begin
         o_ppfifo_stb <= load;
         if (activate) begin
            o_ppfifo_act <= 1'b1;
            r_size       <= i_ppfifo_size;
            r_keep       <= i_last_keep;
            r_count      <= '0;
            r_first      <= 1'b1;
         end else if (state == RELEASE) begin
            o_ppfifo_act <= 1'b0;
         end

         // A pending final beat of the previous block holds until ready
         if (load) begin
            o_axi_data  <= i_ppfifo_data;
            o_axi_valid <= 1'b1;
            o_axi_user  <= r_first;
            o_axi_last  <= load_last;
            o_axi_keep  <= load_last ? r_keep : '1;
            r_first     <= 1'b0;
            r_count     <= r_count + SIZE_WIDTH'(1);
         end else if (i_axi_ready) begin
            o_axi_valid <= 1'b0;
         end

         if (accept) begin
            o_beat_count <= o_beat_count + COUNT_WIDTH'(1);
            if (o_axi_last) o_block_count <= o_block_count + COUNT_WIDTH'(1);
         end
      end
   end

endmodule

// File: tb/tb_ppfifo_2_axi_stream_pkt.sv
// Scoreboard bench for ppfifo_2_axi_stream_pkt: 32-bit and 64-bit instances fed
// from a small PPFIFO model, beats compared in order against queued expectations.
module tb_ppfifo_2_axi_stream_pkt;

   typedef struct {
      logic [63:0] data;
      logic        last;
      logic [7:0]  keep;
      logic        user;
   } beat_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ready, rdy32, rdy64;
   logic [23:0] size_in;
   logic [3:0]  keep32;
   logic [7:0]  keep64;
   logic [31:0] data32;
   logic [63:0] data64;

   logic        act32, stb32, aclk32, valid32, last32, user32, busy32;
   logic [31:0] d32, bc32, bt32;
   logic [3:0]  k32;
   logic        act64, stb64, aclk64, valid64, last64, user64, busy64;
   logic [63:0] d64;
   logic [7:0]  k64;
   logic [31:0] bc64, bt64;

   logic [31:0] mem32 [64];
   logic [63:0] mem64 [64];
   logic [5:0]  head32, head64, wr32, wr64;

   beat_t       exp_q[$];
   int unsigned n_checks = 0, n_pass = 0;
   logic [31:0] exp_blocks = '0, exp_beats = '0;

   always #5 clk = ~clk;

   ppfifo_2_axi_stream_pkt dut32 (
      .clk(clk), .rst_n(rst_n), .i_ppfifo_rdy(rdy32), .o_ppfifo_act(act32),
      .i_ppfifo_size(size_in), .i_ppfifo_data(data32), .o_ppfifo_stb(stb32),
      .i_last_keep(keep32), .o_axi_clk(aclk32), .i_axi_ready(ready),
      .o_axi_valid(valid32), .o_axi_data(d32), .o_axi_keep(k32), .o_axi_last(last32),
      .o_axi_user(user32), .o_busy(busy32), .o_block_count(bc32), .o_beat_count(bt32)
   );

   ppfifo_2_axi_stream_pkt #(.DATA_WIDTH(64)) dut64 (
      .clk(clk), .rst_n(rst_n), .i_ppfifo_rdy(rdy64), .o_ppfifo_act(act64),
      .i_ppfifo_size(size_in), .i_ppfifo_data(data64), .o_ppfifo_stb(stb64),
      .i_last_keep(keep64), .o_axi_clk(aclk64), .i_axi_ready(ready),
      .o_axi_valid(valid64), .o_axi_data(d64), .o_axi_keep(k64), .o_axi_last(last64),
      .o_axi_user(user64), .o_busy(busy64), .o_block_count(bc64), .o_beat_count(bt64)
   );

   // PPFIFO model: the word after the popped one is visible while stb is high
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head32 <= '0;
         head64 <= '0;
      end else begin
         if (stb32) head32 <= head32 + 6'd1;
         if (stb64) head64 <= head64 + 6'd1;
      end
   end
   assign data32 = mem32[head32 + {5'd0, stb32}];
   assign data64 = mem64[head64 + {5'd0, stb64}];

   function automatic logic [73:0] obs32();
      return {32'h0, d32, last32, 4'h0, k32, user32};
   endfunction

   function automatic logic [73:0] obs64();
      return {d64, last64, k64, user64};
   endfunction

   function automatic logic [73:0] pack(input beat_t e);
      return {e.data, e.last, e.keep, e.user};
   endfunction

   function automatic logic [105:0] outs32();
      return {act32, stb32, valid32, d32, k32, last32, user32, busy32, bc32, bt32};
   endfunction

   task automatic load_block(input bit wide, input int unsigned size,
                             input logic [63:0] base, input logic [7:0] keep);
      beat_t e;
      for (int unsigned i = 0; i < size; i++) begin
         if (wide) begin
            mem64[wr64] = base + 64'(i);
            wr64 = wr64 + 6'd1;
         end else begin
            mem32[wr32] = base[31:0] + i;
            wr32 = wr32 + 6'd1;
         end
         e.data = wide ? base + 64'(i) : {32'h0, base[31:0] + i};
         e.last = (i == size - 1);
         e.keep = e.last ? keep : (wide ? 8'hFF : 8'h0F);
         e.user = (i == 0);
         exp_q.push_back(e);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; ready = 1'b0; rdy32 = 1'b0; rdy64 = 1'b0;
      size_in = '0; keep32 = '0; keep64 = '0; wr32 = '0; wr64 = '0;
      repeat (2) @(negedge clk);
      n_checks++;
      if (outs32() !== '0) $display("FAIL reset32: outputs=%h want 0", outs32());
      else n_pass++;
      n_checks++;
      if ({act64, stb64, valid64, d64, k64, last64, user64, busy64, bc64, bt64} !== '0)
         $display("FAIL reset64: act=%b valid=%b data=%h keep=%h counts=%h/%h want all 0",
                  act64, valid64, d64, k64, bc64, bt64);
      else n_pass++;
      n_checks++;
      if (aclk32 !== clk) $display("FAIL axi_clk: got %b want %b", aclk32, clk);
      else n_pass++;
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      beat_t e;
      int          first_v = -1;
      int unsigned act_n = 0, stb_n = 0;
      load_block(1'b0, 4, 64'h10, 8'h03);
      size_in = 24'd4; keep32 = 4'h3; ready = 1'b1; rdy32 = 1'b1;
      for (int c = 0; c < 16; c++) begin
         @(negedge clk);
         if (act32) begin rdy32 = 1'b0; act_n++; end
         if (stb32) stb_n++;
         if (valid32 && first_v < 0) first_v = c;
         if (valid32 && ready) begin
            n_checks++;
            if (exp_q.size() == 0) $display("FAIL basic_beat: got %h, nothing expected", obs32());
            else begin
               e = exp_q.pop_front();
               if (obs32() !== pack(e)) $display("FAIL basic_beat: got %h want %h", obs32(), pack(e));
               else n_pass++;
            end
         end
      end
      exp_blocks += 1; exp_beats += 4;
      n_checks++; if (first_v != 1) $display("FAIL basic_latency: first valid cycle %0d want 1", first_v); else n_pass++;
      n_checks++; if (act_n != 5) $display("FAIL basic_act_len: got %0d want 5", act_n); else n_pass++;
      n_checks++; if (stb_n != 4) $display("FAIL basic_stb: got %0d want 4", stb_n); else n_pass++;
      n_checks++; if (exp_q.size() != 0) $display("FAIL basic_missing: %0d beats never seen, want 0", exp_q.size()); else n_pass++;
      n_checks++; if ({bc32, bt32} !== {exp_blocks, exp_beats}) $display("FAIL basic_counts: got %0d/%0d want %0d/%0d", bc32, bt32, exp_blocks, exp_beats); else n_pass++;
      n_checks++; if (busy32 !== 1'b0) $display("FAIL basic_busy: got %b want 0", busy32); else n_pass++;
   endtask

   task automatic test_backpressure();
      beat_t       e;
      logic [73:0] held = '0;
      bit          holding = 1'b0;
      int unsigned stb_n = 0;
      logic [6:0]  pat = 7'b1101001;
      load_block(1'b0, 3, 64'h20, 8'h07);
      size_in = 24'd3; keep32 = 4'h7; rdy32 = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (act32) rdy32 = 1'b0;
         if (stb32) stb_n++;
         if (holding) begin
            n_checks++;
            if ({valid32, obs32()} !== {1'b1, held})
               $display("FAIL bp_hold: got valid=%b %h want valid=1 %h", valid32, obs32(), held);
            else n_pass++;
         end
         ready = (c < 7) ? pat[c] : 1'b1;
         holding = valid32 && !ready;
         held = obs32();
         if (valid32 && ready) begin
            n_checks++;
            if (exp_q.size() == 0) $display("FAIL bp_beat: got %h, nothing expected", obs32());
            else begin
               e = exp_q.pop_front();
               if (obs32() !== pack(e)) $display("FAIL bp_beat: got %h want %h", obs32(), pack(e));
               else n_pass++;
            end
         end
      end
      exp_blocks += 1; exp_beats += 3;
      n_checks++; if (stb_n != 3) $display("FAIL bp_stb: got %0d want 3", stb_n); else n_pass++;
      n_checks++; if (exp_q.size() != 0) $display("FAIL bp_missing: %0d beats never seen, want 0", exp_q.size()); else n_pass++;
      n_checks++; if ({bc32, bt32} !== {exp_blocks, exp_beats}) $display("FAIL bp_counts: got %0d/%0d want %0d/%0d", bc32, bt32, exp_blocks, exp_beats); else n_pass++;
   endtask

   task automatic test_size1();
      beat_t e;
      int unsigned stb_n = 0;
      load_block(1'b0, 1, 64'h30, 8'h05);
      size_in = 24'd1; keep32 = 4'h5; ready = 1'b1; rdy32 = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (act32) rdy32 = 1'b0;
         if (stb32) stb_n++;
         if (valid32 && ready) begin
            n_checks++;
            if (exp_q.size() == 0) $display("FAIL size1_beat: got %h, nothing expected", obs32());
            else begin
               e = exp_q.pop_front();
               if (obs32() !== pack(e)) $display("FAIL size1_beat: got %h want %h", obs32(), pack(e));
               else n_pass++;
            end
         end
      end
      exp_blocks += 1; exp_beats += 1;
      n_checks++; if (stb_n != 1) $display("FAIL size1_stb: got %0d want 1", stb_n); else n_pass++;
      n_checks++; if (exp_q.size() != 0) $display("FAIL size1_missing: %0d beats never seen, want 0", exp_q.size()); else n_pass++;
      n_checks++; if ({bc32, bt32} !== {exp_blocks, exp_beats}) $display("FAIL size1_counts: got %0d/%0d want %0d/%0d", bc32, bt32, exp_blocks, exp_beats); else n_pass++;
   endtask

   task automatic test_zero();
      int unsigned act_n = 0, valid_n = 0, stb_n = 0;
      size_in = '0; keep32 = 4'h1; ready = 1'b1; rdy32 = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (act32) begin rdy32 = 1'b0; act_n++; end
         if (valid32) valid_n++;
         if (stb32) stb_n++;
      end
      n_checks++; if (act_n != 1) $display("FAIL zero_act: got %0d cycles want 1", act_n); else n_pass++;
      n_checks++; if (valid_n != 0) $display("FAIL zero_valid: got %0d cycles want 0", valid_n); else n_pass++;
      n_checks++; if (stb_n != 0) $display("FAIL zero_stb: got %0d want 0", stb_n); else n_pass++;
      n_checks++; if ({bc32, bt32} !== {exp_blocks, exp_beats}) $display("FAIL zero_counts: got %0d/%0d want %0d/%0d", bc32, bt32, exp_blocks, exp_beats); else n_pass++;
   endtask

   task automatic test_back_to_back();
      beat_t       e;
      int unsigned acts = 0, hold_n = 0;
      logic        prev_act = 1'b0;
      bit          overlap = 1'b0;
      load_block(1'b0, 2, 64'hA0, 8'h01);
      load_block(1'b0, 2, 64'hB0, 8'h0E);
      size_in = 24'd2; keep32 = 4'h1; ready = 1'b1; rdy32 = 1'b1;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         if (act32 && !prev_act) begin
            acts++;
            keep32 = 4'hE;
            if (acts == 2) begin
               rdy32 = 1'b0;
               if (valid32 && last32) overlap = 1'b1;
            end
         end
         prev_act = act32;
         ready = !(valid32 && last32 && hold_n < 3);
         if (!ready) hold_n++;
         if (valid32 && ready) begin
            n_checks++;
            if (exp_q.size() == 0) $display("FAIL b2b_beat: got %h, nothing expected", obs32());
            else begin
               e = exp_q.pop_front();
               if (obs32() !== pack(e)) $display("FAIL b2b_beat: got %h want %h", obs32(), pack(e));
               else n_pass++;
            end
         end
      end
      exp_blocks += 2; exp_beats += 4;
      n_checks++; if (acts != 2) $display("FAIL b2b_acts: got %0d want 2", acts); else n_pass++;
      n_checks++; if (overlap != 1'b1) $display("FAIL b2b_overlap: got %b want 1", overlap); else n_pass++;
      n_checks++; if (exp_q.size() != 0) $display("FAIL b2b_missing: %0d beats never seen, want 0", exp_q.size()); else n_pass++;
      n_checks++; if ({bc32, bt32} !== {exp_blocks, exp_beats}) $display("FAIL b2b_counts: got %0d/%0d want %0d/%0d", bc32, bt32, exp_blocks, exp_beats); else n_pass++;
   endtask

   task automatic test_width64();
      beat_t       e;
      int          first_v = -1;
      int unsigned stb_n = 0;
      load_block(1'b1, 4, 64'hDEAD_BEEF_0000_0040, 8'h0F);
      size_in = 24'd4; keep64 = 8'h0F; ready = 1'b1; rdy64 = 1'b1;
      for (int c = 0; c < 16; c++) begin
         @(negedge clk);
         if (act64) rdy64 = 1'b0;
         if (stb64) stb_n++;
         if (valid64 && first_v < 0) first_v = c;
         if (valid64 && ready) begin
            n_checks++;
            if (exp_q.size() == 0) $display("FAIL w64_beat: got %h, nothing expected", obs64());
            else begin
               e = exp_q.pop_front();
               if (obs64() !== pack(e)) $display("FAIL w64_beat: got %h want %h", obs64(), pack(e));
               else n_pass++;
            end
         end
      end
      n_checks++; if (first_v != 1) $display("FAIL w64_latency: first valid cycle %0d want 1", first_v); else n_pass++;
      n_checks++; if (stb_n != 4) $display("FAIL w64_stb: got %0d want 4", stb_n); else n_pass++;
      n_checks++; if (exp_q.size() != 0) $display("FAIL w64_missing: %0d beats never seen, want 0", exp_q.size()); else n_pass++;
      n_checks++; if ({bc64, bt64} !== {32'd1, 32'd4}) $display("FAIL w64_counts: got %0d/%0d want 1/4", bc64, bt64); else n_pass++;
   endtask

   task automatic test_reset_mid();
      beat_t       e;
      int unsigned accepted = 0;
      load_block(1'b0, 5, 64'h50, 8'h0F);
      size_in = 24'd5; keep32 = 4'hF; ready = 1'b1; rdy32 = 1'b1;
      for (int c = 0; c < 20 && accepted < 2; c++) begin
         @(negedge clk);
         if (act32) rdy32 = 1'b0;
         if (valid32 && ready) begin
            n_checks++;
            e = exp_q.pop_front();
            if (obs32() !== pack(e)) $display("FAIL mid_beat: got %h want %h", obs32(), pack(e));
            else n_pass++;
            accepted++;
         end
      end
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if (outs32() !== '0) $display("FAIL mid_reset: outputs=%h want 0", outs32());
      else n_pass++;
      exp_q.delete();
      wr32 = '0; exp_blocks = '0; exp_beats = '0;
      @(negedge clk);
      rst_n = 1'b1;
      load_block(1'b0, 2, 64'h60, 8'h03);
      size_in = 24'd2; keep32 = 4'h3; rdy32 = 1'b1;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (act32) rdy32 = 1'b0;
         if (valid32 && ready) begin
            n_checks++;
            if (exp_q.size() == 0) $display("FAIL mid_fresh_beat: got %h, nothing expected", obs32());
            else begin
               e = exp_q.pop_front();
               if (obs32() !== pack(e)) $display("FAIL mid_fresh_beat: got %h want %h", obs32(), pack(e));
               else n_pass++;
            end
         end
      end
      exp_blocks += 1; exp_beats += 2;
      n_checks++; if (exp_q.size() != 0) $display("FAIL mid_missing: %0d beats never seen, want 0", exp_q.size()); else n_pass++;
      n_checks++; if ({bc32, bt32} !== {exp_blocks, exp_beats}) $display("FAIL mid_counts: got %0d/%0d want %0d/%0d", bc32, bt32, exp_blocks, exp_beats); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_size1();
      test_zero();
      test_back_to_back();
      test_width64();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
